aurora_tx_pkt_fifo: RTL and testbench

Parametrised synchronous FIFO for the Aurora TX AXI-Stream path, replacing the vendor-macro TX FIFO with an inferred-memory design. Supports pass-through stream mode and store-and-forward packet mode. Store-and-forward mode withholds a frame from the Aurora core until its `tlast` word is stored, so the core never sees an idle gap inside a frame. The block sits between the user TX stream and the Aurora core TX AXI-S port, all in the user clock domain.

---
 rtl/aurora_pkg.sv | 27 ++
 rtl/aurora_sdp_ram.sv | 29 ++
 rtl/aurora_tx_pkt_fifo.sv | 159 +++++++++++++++
 tb/tb_aurora_tx_pkt_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora TX stream path: a width helper and the
// reference layout of a stored AXI-Stream word.
package aurora_pkg;

   // Ceiling log2 with a floor of 1, so a one-entry structure still gets an address bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'd1 << i) < n) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Reference stored-word layout for the default 8-bit stream; modules with other
   // widths declare a parameterised struct of the same shape.
   typedef struct packed {
      logic [7:0] data;
      logic [0:0] keep;
      logic       last;
   } aurora_axis_word_t;

endpackage

// File: rtl/aurora_sdp_ram.sv
// Simple dual-port memory: synchronous write, asynchronous read. No reset on the
// array so it maps onto distributed RAM.
module aurora_sdp_ram
   import aurora_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 32,
   parameter int AW    = clog2_min1(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Store the incoming word on an accepted write.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aurora_tx_pkt_fifo.sv
// Aurora TX AXI-Stream FIFO with stream (first-word fall-through) and
// store-and-forward packet modes. Packet mode holds a frame back until its tlast
// word is stored; a bypass flag breaks the deadlock when a frame exceeds the depth.
module aurora_tx_pkt_fifo
   import aurora_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int KEEP_W      = DATA_W / 8,
   parameter int FIFO_DEPTH  = 32,
   parameter bit PACKET_MODE = 1'b1,
   parameter int INIT_CYCLES = 4,
   parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              rst_n,
   input  logic              clk,
   output logic              fifo_ready,
   output logic [CNT_W-1:0]  used_words,
   output logic [CNT_W-1:0]  pkt_count,
   input  logic [DATA_W-1:0] i_tdata,
   input  logic [KEEP_W-1:0] i_tkeep,
   input  logic              i_tvalid,
   input  logic              i_tlast,
   output logic              i_tready,
   output logic [DATA_W-1:0] o_tdata,
   output logic [KEEP_W-1:0] o_tkeep,
   output logic              o_tlast,
   output logic              o_tvalid,
   input  logic              o_tready
);

   localparam int AW = clog2_min1(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int IW = clog2_min1(INIT_CYCLES + 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
   } word_t;

   localparam int WORD_W = $bits(word_t);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] pkt_q, pkt_d;
   logic             bypass_q, bypass_d;
   logic [IW-1:0]    init_cnt_q;
   logic             ready_q;

   logic             full_s;
   logic             empty_s;
   logic             release_s;
   logic             wr_en_s;
   logic             rd_en_s;
   logic [PW-1:0]    used_s;
   word_t            wr_word_s;
   word_t            rd_word_s;

   assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_s = (wr_ptr_q == rd_ptr_q);
   assign used_s  = wr_ptr_q - rd_ptr_q;

   // Stream mode always releases; packet mode waits for a whole frame or the deadlock bypass.
   assign release_s = (PACKET_MODE == 1'b0) || (pkt_q != {CNT_W{1'b0}}) || bypass_q;

   assign i_tready = ready_q & ~full_s;
   assign o_tvalid = ready_q & ~empty_s & release_s;
   assign wr_en_s  = i_tvalid & i_tready;
   assign rd_en_s  = o_tvalid & o_tready;

   assign wr_word_s = '{data: i_tdata, keep: i_tkeep, last: i_tlast};

   aurora_sdp_ram #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en_s),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (wr_word_s),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rd_word_s)
   );

   // Payload is forced to zero whenever nothing is being presented, including reset.
   assign o_tdata    = o_tvalid ? rd_word_s.data : {DATA_W{1'b0}};
   assign o_tkeep    = o_tvalid ? rd_word_s.keep : {KEEP_W{1'b0}};
   assign o_tlast    = o_tvalid & rd_word_s.last;
   assign fifo_ready = ready_q;
   assign used_words = CNT_W'(used_s);
   assign pkt_count  = pkt_q;

   // Next-state for pointers, frame counter and bypass flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      pkt_d    = pkt_q;
      bypass_d = bypass_q;

      if (wr_en_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (rd_en_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({wr_en_s & i_tlast, rd_en_s & rd_word_s.last})
         2'b10:   pkt_d = pkt_q + CNT_W'(1);
         2'b01:   pkt_d = pkt_q - CNT_W'(1);
         default: pkt_d = pkt_q;
      endcase

      if (PACKET_MODE == 1'b0) begin
         bypass_d = 1'b0;
      end else if (rd_en_s && rd_word_s.last) begin
         bypass_d = 1'b0;
      end else if (full_s && (pkt_q == {CNT_W{1'b0}})) begin
         bypass_d = 1'b1;
      end else begin
         bypass_d = bypass_q;
      end
   end

   // FIFO state registers; reset discards all stored contents at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         pkt_q    <= {CNT_W{1'b0}};
         bypass_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pkt_q    <= pkt_d;
         bypass_q <= bypass_d;
      end
   end

   // Hold the FIFO closed for INIT_CYCLES edges after reset release, then stay ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_cnt_q <= {IW{1'b0}};
         ready_q    <= 1'b0;
      end else if (!ready_q) begin
         if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
            ready_q <= 1'b1;
         end else begin
            init_cnt_q <= init_cnt_q + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_aurora_tx_pkt_fifo.sv
// Directed and randomised bench for aurora_tx_pkt_fifo: stream mode depth 32,
// packet mode depth 32 and packet mode depth 16, checked against queue models.
module tb_aurora_tx_pkt_fifo;

   localparam int CW32 = 6;
   localparam int CW16 = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // stream instance
   logic [7:0] s_itd, s_otd;
   logic s_itk, s_itv, s_itl, s_ir, s_rdy, s_ov, s_otl, s_otk, s_otr;
   logic [CW32-1:0] s_used, s_pkt;
   // packet instance, depth 32
   logic [7:0] p_itd, p_otd;
   logic p_itk, p_itv, p_itl, p_ir, p_rdy, p_ov, p_otl, p_otk, p_otr;
   logic [CW32-1:0] p_used, p_pkt;
   // packet instance, depth 16
   logic [7:0] q_itd, q_otd;
   logic q_itk, q_itv, q_itl, q_ir, q_rdy, q_ov, q_otl, q_otk, q_otr;
   logic [CW16-1:0] q_used, q_pkt;

   aurora_tx_pkt_fifo #(.DATA_W(8), .KEEP_W(1), .FIFO_DEPTH(32), .PACKET_MODE(1'b0), .INIT_CYCLES(4)) s_dut (
      .rst_n(rst_n), .clk(clk), .fifo_ready(s_rdy), .used_words(s_used), .pkt_count(s_pkt),
      .i_tdata(s_itd), .i_tkeep(s_itk), .i_tvalid(s_itv), .i_tlast(s_itl), .i_tready(s_ir),
      .o_tdata(s_otd), .o_tkeep(s_otk), .o_tlast(s_otl), .o_tvalid(s_ov), .o_tready(s_otr));

   aurora_tx_pkt_fifo #(.DATA_W(8), .KEEP_W(1), .FIFO_DEPTH(32), .PACKET_MODE(1'b1), .INIT_CYCLES(4)) p_dut (
      .rst_n(rst_n), .clk(clk), .fifo_ready(p_rdy), .used_words(p_used), .pkt_count(p_pkt),
      .i_tdata(p_itd), .i_tkeep(p_itk), .i_tvalid(p_itv), .i_tlast(p_itl), .i_tready(p_ir),
      .o_tdata(p_otd), .o_tkeep(p_otk), .o_tlast(p_otl), .o_tvalid(p_ov), .o_tready(p_otr));

   aurora_tx_pkt_fifo #(.DATA_W(8), .KEEP_W(1), .FIFO_DEPTH(16), .PACKET_MODE(1'b1), .INIT_CYCLES(4)) q_dut (
      .rst_n(rst_n), .clk(clk), .fifo_ready(q_rdy), .used_words(q_used), .pkt_count(q_pkt),
      .i_tdata(q_itd), .i_tkeep(q_itk), .i_tvalid(q_itv), .i_tlast(q_itl), .i_tready(q_ir),
      .o_tdata(q_otd), .o_tkeep(q_otk), .o_tlast(q_otl), .o_tvalid(q_ov), .o_tready(q_otr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rst(input string ph);
      chk({ph, "_s_rdy"},  32'(s_rdy),  32'd0);
      chk({ph, "_s_ir"},   32'(s_ir),   32'd0);
      chk({ph, "_s_ov"},   32'(s_ov),   32'd0);
      chk({ph, "_s_used"}, 32'(s_used), 32'd0);
      chk({ph, "_p_rdy"},  32'(p_rdy),  32'd0);
      chk({ph, "_p_ir"},   32'(p_ir),   32'd0);
      chk({ph, "_p_ov"},   32'(p_ov),   32'd0);
      chk({ph, "_p_used"}, 32'(p_used), 32'd0);
      chk({ph, "_p_pkt"},  32'(p_pkt),  32'd0);
      chk({ph, "_p_otd"},  32'(p_otd),  32'd0);
      chk({ph, "_p_otl"},  32'(p_otl),  32'd0);
      chk({ph, "_q_ov"},   32'(q_ov),   32'd0);
      chk({ph, "_q_pkt"},  32'(q_pkt),  32'd0);
   endtask

   logic [8:0] sq [$];
   logic [8:0] pq [$];
   logic [8:0] pm [$];
   logic [7:0] wd [20];
   int n, sent, got;
   logic saw_bypass, acc, rd, eir, eov, wa, ra;

   initial begin
      {s_itd, s_itk, s_itv, s_itl, s_otr} = '0;
      {p_itd, p_itk, p_itv, p_itl, p_otr} = '0;
      {q_itd, q_itk, q_itv, q_itl, q_otr} = '0;

      // reset state and init delay
      repeat (3) @(posedge clk);
      #1;
      chk_rst("reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("init_p_rdy", 32'(p_rdy), 32'(k >= 4));
         chk("init_p_ir",  32'(p_ir),  32'(k >= 4));
         if (k == 4) begin
            chk("init_s_rdy", 32'(s_rdy), 32'd1);
            chk("init_q_rdy", 32'(q_rdy), 32'd1);
         end
      end

      // stream mode: overfill with output stalled, then drain
      s_otr = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         s_itv = 1'b1;
         s_itd = 8'($urandom);
         s_itk = 1'($urandom);
         chk("s_itready", 32'(s_ir), 32'(n < 32));
         tick();
         if (n < 32) begin
            sq.push_back({s_itk, s_itd});
            n++;
         end
         chk("s_used", 32'(s_used), 32'(n));
         if (i == 0) chk("s_fwft_valid", 32'(s_ov), 32'd1);
      end
      s_itv = 1'b0;
      chk("s_full_itready", 32'(s_ir), 32'd0);
      for (int i = 0; i < 32; i++) begin
         s_otr = 1'b1;
         chk("s_ov", 32'(s_ov), 32'd1);
         chk("s_data", 32'({s_otk, s_otd}), 32'(sq[i]));
         tick();
      end
      s_otr = 1'b0;
      chk("s_drained_ov", 32'(s_ov), 32'd0);
      chk("s_drained_used", 32'(s_used), 32'd0);

      // packet mode: 5-word frame withheld until tlast stored
      p_otr = 1'b1;
      chk("p_pkt_start", 32'(p_pkt), 32'd0);
      for (int i = 0; i < 5; i++) begin
         p_itv = 1'b1;
         p_itd = 8'($urandom);
         p_itk = 1'($urandom);
         p_itl = (i == 4);
         chk("p_hold_ov", 32'(p_ov), 32'd0);
         tick();
         pq.push_back({p_itk, p_itd});
         if (i < 4) chk("p_pkt_partial", 32'(p_pkt), 32'd0);
      end
      p_itv = 1'b0;
      p_itl = 1'b0;
      chk("p_pkt_one", 32'(p_pkt), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("p_ov", 32'(p_ov), 32'd1);
         chk("p_data", 32'({p_otk, p_otd}), 32'(pq[i]));
         chk("p_last", 32'(p_otl), 32'(i == 4));
         chk("p_pkt_during", 32'(p_pkt), 32'd1);
         tick();
      end
      chk("p_pkt_zero", 32'(p_pkt), 32'd0);
      chk("p_done_ov", 32'(p_ov), 32'd0);
      chk("p_done_used", 32'(p_used), 32'd0);

      // packet mode depth 16: 20-word frame needs the bypass
      for (int i = 0; i < 20; i++) wd[i] = 8'($urandom);
      q_otr = 1'b1;
      sent = 0;
      got = 0;
      saw_bypass = 1'b0;
      for (int c = 0; c < 300 && got < 20; c++) begin
         q_itv = (sent < 20);
         q_itd = wd[sent % 20];
         q_itl = (sent == 19);
         acc = q_itv & q_ir;
         rd  = q_ov & q_otr;
         if (q_dut.bypass_q) saw_bypass = 1'b1;
         if (rd) begin
            if (got == 0) chk("q_first_rd_bypass", 32'(q_dut.bypass_q), 32'd1);
            chk("q_data", 32'(q_otd), 32'(wd[got]));
            chk("q_last", 32'(q_otl), 32'(got == 19));
         end
         tick();
         if (acc) sent++;
         if (rd) got++;
      end
      q_itv = 1'b0;
      q_itl = 1'b0;
      chk("q_delivered", 32'(got), 32'd20);
      chk("q_saw_bypass", 32'(saw_bypass), 32'd1);
      chk("q_bypass_clear", 32'(q_dut.bypass_q), 32'd0);
      chk("q_used", 32'(q_used), 32'd0);
      chk("q_pkt", 32'(q_pkt), 32'd0);

      // random concurrent traffic, 1-word frames
      for (int c = 0; c < 10000; c++) begin
         p_itv = 1'($urandom_range(0, 1));
         p_otr = 1'($urandom_range(0, 1));
         p_itd = 8'($urandom);
         p_itk = 1'($urandom);
         p_itl = 1'b1;
         eir = (pm.size() < 32);
         eov = (pm.size() > 0);
         chk("r_itready", 32'(p_ir), 32'(eir));
         chk("r_ov", 32'(p_ov), 32'(eov));
         if (eov && p_otr) chk("r_data", 32'({p_otk, p_otd}), 32'(pm[0]));
         wa = p_itv & eir;
         ra = eov & p_otr;
         tick();
         if (ra) void'(pm.pop_front());
         if (wa) pm.push_back({p_itk, p_itd});
         chk("r_used", 32'(p_used), 32'(pm.size()));
         chk("r_pkt", 32'(p_pkt), 32'(pm.size()));
      end

      // drain, load three frames, then reset mid-cycle
      p_itv = 1'b0;
      p_otr = 1'b1;
      repeat (40) tick();
      p_otr = 1'b0;
      p_itv = 1'b1;
      repeat (3) tick();
      p_itv = 1'b0;
      chk("pre_rst_used", 32'(p_used), 32'd3);
      chk("pre_rst_pkt", 32'(p_pkt), 32'd3);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_rst("midreset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
